// File: rtl/seq_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module   : seq_mag_comparator
// Purpose  : Multi-cycle magnitude comparator. It compares two N-bit operands
//            MSB-first, D bits per clock, and stops early at the first slice
//            that differs. Each operation selects unsigned or two's-complement
//            mode. The start/busy/done handshake controls each operation.
// Options  : Define SEQ_MAG_CMP_LATCNT_EN to add the lat_cnt output. It holds
//            the number of slices examined by the most recent compare.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mag_comparator #(
   parameter int N = 8,
   parameter int D = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         signed_mode,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         L_T,
   output logic         G_T,
   output logic         E
`ifdef SEQ_MAG_CMP_LATCNT_EN
   ,
   output logic [$clog2(N/D):0] lat_cnt
`endif
);

   localparam int C_S     = N / D;
   localparam int C_IDX_W = (C_S > 1) ? $clog2(C_S) : 1;
`ifdef SEQ_MAG_CMP_LATCNT_EN
   localparam int C_LAT_W = $clog2(C_S) + 1;
`endif
   localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_S - 1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COMPARE = 1'b1
   } state_t;

   state_t             r_state;
   logic [N-1:0]       r_a;
   logic [N-1:0]       r_b;
   logic [C_IDX_W-1:0] r_idx;

   // The operand registers shift left after each equal slice. The slice under
   // test is therefore always the top D bits, and no variable part-select is
   // needed.
   logic [D-1:0] w_a_top;
   logic [D-1:0] w_b_top;
   logic [N-1:0] w_a_next;
   logic [N-1:0] w_b_next;
   logic         w_slice_lt;
   logic         w_slice_gt;
   logic         w_slice_ne;
   logic         w_last;

   assign w_a_top    = r_a[N-1 -: D];
   assign w_b_top    = r_b[N-1 -: D];
   assign w_slice_lt = (w_a_top < w_b_top);
   assign w_slice_gt = (w_a_top > w_b_top);
   assign w_slice_ne = w_slice_lt | w_slice_gt;
   assign w_last     = (r_idx == C_LAST_IDX);

   // With a single slice nothing follows, so the operands are held as they are.
   generate
      if (D < N) begin : g_shift
         assign w_a_next = r_a << D;
         assign w_b_next = r_b << D;
      end else begin : g_no_shift
         assign w_a_next = r_a;
         assign w_b_next = r_b;
      end
   endgenerate

   // Control FSM, operand shifter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         L_T     <= 1'b0;
         G_T     <= 1'b0;
         E       <= 1'b0;
`ifdef SEQ_MAG_CMP_LATCNT_EN
         lat_cnt <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  // Flipping the sign bit maps two's complement to offset
                  // binary. An unsigned slice compare then orders the values
                  // correctly.
                  r_a     <= {A[N-1] ^ signed_mode, A[N-2:0]};
                  r_b     <= {B[N-1] ^ signed_mode, B[N-2:0]};
                  r_idx   <= '0;
                  busy    <= 1'b1;
                  r_state <= COMPARE;
               end
            end
            COMPARE: begin
               if (w_slice_ne || w_last) begin
                  L_T     <= w_slice_lt;
                  G_T     <= w_slice_gt;
                  E       <= ~w_slice_ne;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= IDLE;
`ifdef SEQ_MAG_CMP_LATCNT_EN
                  lat_cnt <= C_LAT_W'(r_idx) + C_LAT_W'(1);
`endif
               end else begin
                  r_a   <= w_a_next;
                  r_b   <= w_b_next;
                  r_idx <= r_idx + C_IDX_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mag_comparator
// Purpose  : Directed self-checking bench for seq_mag_comparator (N=8, D=2).
//            Define SEQ_MAG_CMP_LATCNT_EN to also check lat_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mag_comparator;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       signed_mode;
   logic [7:0] A;
   logic [7:0] B;
   logic       busy;
   logic       done;
   logic       L_T;
   logic       G_T;
   logic       E;
`ifdef SEQ_MAG_CMP_LATCNT_EN
   logic [2:0] lat_cnt;
`endif

   int n_vec;
   int n_err;

   seq_mag_comparator #(.N(8), .D(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_mode (signed_mode),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .L_T         (L_T),
      .G_T         (G_T),
      .E           (E)
`ifdef SEQ_MAG_CMP_LATCNT_EN
      ,
      .lat_cnt     (lat_cnt)
`endif
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; sample 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check the three result flags, packed as {L_T, G_T, E}.
   task automatic chk_res(input string tag, input logic [2:0] exp);
      chk(tag, {5'd0, L_T, G_T, E}, {5'd0, exp});
   endtask

   task automatic chk_lat(input string tag, input logic [7:0] exp);
`ifdef SEQ_MAG_CMP_LATCNT_EN
      chk(tag, {5'd0, lat_cnt}, exp);
`else
      if (exp == 8'hEE) $error("FAIL %s bad use", tag);
`endif
   endtask

   // Drive one start cycle; on return the start edge has passed.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic sm);
      A = a; B = b; signed_mode = sm; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;

      // Reset state.
      tick(); tick();
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk_res("rst_res", 3'b000);
      chk_lat("rst_lat", 8'd0);
      rst_n = 1'b1;
      tick(); tick();
      chk("idle_busy", {7'd0, busy}, 8'd0);
      chk_res("idle_res", 3'b000);

      // Unsigned early exit: 0xC3 vs 0x43 differs in slice 0.
      launch(8'hC3, 8'h43, 1'b0);
      chk("u_busy0", {7'd0, busy}, 8'd1);
      chk("u_done0", {7'd0, done}, 8'd0);
      tick();
      chk("u_done1", {7'd0, done}, 8'd1);
      chk("u_busy1", {7'd0, busy}, 8'd0);
      chk_res("u_res", 3'b010);
      chk_lat("u_lat", 8'd1);
      tick();
      chk("u_done_pulse", {7'd0, done}, 8'd0);

      // Equal operands: four slices, then hold for ten cycles.
      launch(8'h5A, 8'h5A, 1'b0);
      chk("eq_busy_c0", {7'd0, busy}, 8'd1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("eq_busy_c%0d", i), {6'd0, busy, done}, 8'b10);
      end
      tick();
      chk("eq_done4", {6'd0, busy, done}, 8'b01);
      chk_res("eq_res", 3'b001);
      chk_lat("eq_lat", 8'd4);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("eq_hold%0d", i), {4'd0, done, L_T, G_T, E}, 8'b0001);
      end

      // Signed: -128 < 1.
      launch(8'h80, 8'h01, 1'b1);
      tick();
      chk("s_done", {7'd0, done}, 8'd1);
      chk_res("s_res", 3'b100);
      chk_lat("s_lat", 8'd1);
      tick();

      // Unsigned: 128 > 1.
      launch(8'h80, 8'h01, 1'b0);
      tick();
      chk("us_done", {7'd0, done}, 8'd1);
      chk_res("us_res", 3'b010);
      tick();

      // Late difference (slice 3). A start pulse while busy is ignored.
      launch(8'h12, 8'h13, 1'b0);
      tick();                                  // cycle 1
      A = 8'hFF; B = 8'h00; start = 1'b1;
      tick();                                  // cycle 2: start ignored
      start = 1'b0;
      chk("late_busy2", {6'd0, busy, done}, 8'b10);
      chk_res("late_hold2", 3'b010);
      tick();                                  // cycle 3
      chk("late_busy3", {6'd0, busy, done}, 8'b10);
      tick();                                  // cycle 4
      chk("late_done4", {6'd0, busy, done}, 8'b01);
      chk_res("late_res", 3'b100);
      chk_lat("late_lat", 8'd4);
      // Start in the done cycle is accepted.
      A = 8'hFF; B = 8'h00; start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_busy", {6'd0, busy, done}, 8'b10);
      chk_res("b2b_hold", 3'b100);
      tick();
      chk("b2b_done", {7'd0, done}, 8'd1);
      chk_res("b2b_res", 3'b010);
      chk_lat("b2b_lat", 8'd1);

      // Asynchronous reset mid-compare.
      launch(8'h12, 8'h13, 1'b0);
      tick();                                  // cycle 1
      chk("ar_busy", {7'd0, busy}, 8'd1);
      chk_res("ar_pre", 3'b010);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_busy_drop", {6'd0, busy, done}, 8'b00);
      chk_res("ar_res_drop", 3'b000);
      chk_lat("ar_lat_drop", 8'd0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("ar_quiet%0d", i), {3'd0, busy, done, L_T, G_T, E}, 8'd0);
      end

      // First compare after reset release: 0x01 < 0x02, decided in slice 3.
      launch(8'h01, 8'h02, 1'b0);
      for (int i = 1; i <= 3; i++) tick();
      chk("pr_busy3", {6'd0, busy, done}, 8'b10);
      tick();
      chk("pr_done4", {6'd0, busy, done}, 8'b01);
      chk_res("pr_res", 3'b100);
      chk_lat("pr_lat", 8'd4);

      // Signed equal negative values.
      launch(8'hF0, 8'hF0, 1'b1);
      for (int i = 1; i <= 4; i++) tick();
      chk("sn_done", {7'd0, done}, 8'd1);
      chk_res("sn_res", 3'b001);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global timeout guard.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
